// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg
//   Shared encodings for the multi-mode waveform generator.
//   - MODE_*  : waveform select codes driven on wave_gen.mode
//   - dir_t   : triangle ramp direction (two-state machine, UP/DN)
package wave_gen_pkg;

    localparam logic [1:0] MODE_TRI    = 2'd0;
    localparam logic [1:0] MODE_SAW_UP = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;
    localparam logic [1:0] MODE_SAW_DN = 2'd3;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

endpackage

// File: rtl/wave_tick_gen.sv
// wave_tick_gen
//   Prescaler: asserts o_tick once every (i_prescaler + 1) enabled cycles.
//   Ports:
//     i_clk       : clock, all logic on posedge
//     i_rst       : synchronous active-high reset, clears the counter
//     i_ena       : run enable; when low the counter is held at 0
//     i_restart   : synchronous phase restart; clears the counter, masks tick
//     i_prescaler : step period minus one (P)
//     o_tick      : combinational, high on the cycle whose edge is a step
module wave_tick_gen #(
    parameter int PRESC_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ena,
    input  logic               i_restart,
    input  logic [PRESC_W-1:0] i_prescaler,
    output logic               o_tick
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] r_count;
    logic               w_at_limit;

    // ">=" rather than "==" so a prescaler lowered below the running count
    // still ticks on the next cycle instead of waiting for a full wrap.
    assign w_at_limit = (r_count >= i_prescaler);
    assign o_tick     = i_ena & ~i_restart & w_at_limit;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart || !i_ena) begin
            r_count <= '0;
        end else if (w_at_limit) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + ONE;
        end
    end

endmodule

// File: rtl/wave_gen.sv
// wave_gen
//   Multi-mode waveform generator: triangle, saw-up, square, saw-down from 0
//   to a live amplitude A, stepping once per prescaler tick.
//   Optional macro WAVE_GEN_SYNC_EN adds input sync_in (phase restart).
//   Ports:
//     clk          : clock
//     rst          : synchronous active-high reset
//     ena          : run enable (phase held while low)
//     mode         : 0 triangle, 1 saw-up, 2 square, 3 saw-down
//     amplitude    : peak value A
//     prescaler    : step period minus one
//     sync_in      : (WAVE_GEN_SYNC_EN only) restart phase
//     data         : registered sample
//     period_start : one-cycle strobe at start of each period
//     o_dbg_dir    : current triangle direction state
//   Handshake: none; data/period_start update only on tick edges and
//   period_start is low on every other cycle.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  amplitude,
    input  logic [PRESC_W-1:0] prescaler,
`ifdef WAVE_GEN_SYNC_EN
    input  logic               sync_in,
`endif
    output logic [DATA_W-1:0]  data,
    output logic               period_start,
    output dir_t               o_dbg_dir
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] r_data, w_data_nx;
    logic              r_ps, w_ps_nx;
    dir_t              r_dir, w_dir_nx;
    logic [DATA_W-1:0] r_cnt, w_cnt_nx;
    logic              r_level, w_level_nx;
    logic [1:0]        r_mode_q;
    logic              w_restart;
    logic              w_tick;

`ifdef WAVE_GEN_SYNC_EN
    assign w_restart = sync_in | (mode != r_mode_q);
`else
    assign w_restart = (mode != r_mode_q);
`endif

    wave_tick_gen #(.PRESC_W(PRESC_W)) u_tick (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ena       (ena),
        .i_restart   (w_restart),
        .i_prescaler (prescaler),
        .o_tick      (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_ps     <= 1'b0;
            r_dir    <= DIR_UP;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_mode_q <= mode;
        end else begin
            r_data   <= w_data_nx;
            r_ps     <= w_ps_nx;
            r_dir    <= w_dir_nx;
            r_cnt    <= w_cnt_nx;
            r_level  <= w_level_nx;
            r_mode_q <= mode;
        end
    end

    always_comb begin
        w_data_nx  = r_data;
        w_ps_nx    = 1'b0;
        w_dir_nx   = r_dir;
        w_cnt_nx   = r_cnt;
        w_level_nx = r_level;
        if (w_restart) begin
            // Restart wins over a coincident tick and never strobes.
            w_data_nx  = '0;
            w_dir_nx   = DIR_UP;
            w_cnt_nx   = '0;
            w_level_nx = 1'b0;
        end else if (w_tick) begin
            case (r_mode_q)
                MODE_TRI: begin
                    if (amplitude == '0) begin
                        w_data_nx = '0;
                    end else if (r_data > amplitude) begin
                        // Amplitude lowered below the sample: clamp, descend.
                        w_data_nx = amplitude;
                        w_dir_nx  = DIR_DN;
                    end else if (r_dir == DIR_UP) begin
                        if (r_data == amplitude) begin
                            w_data_nx = amplitude - ONE;
                            w_dir_nx  = DIR_DN;
                        end else begin
                            w_data_nx = r_data + ONE;
                        end
                    end else if (r_data == '0) begin
                        w_data_nx = ONE;
                        w_dir_nx  = DIR_UP;
                        w_ps_nx   = 1'b1;
                    end else begin
                        w_data_nx = r_data - ONE;
                    end
                end
                MODE_SAW_UP: begin
                    if (r_data >= amplitude) begin
                        w_data_nx = '0;
                        w_ps_nx   = 1'b1;
                    end else begin
                        w_data_nx = r_data + ONE;
                    end
                end
                MODE_SQUARE: begin
                    if (r_cnt >= amplitude) begin
                        w_cnt_nx   = '0;
                        w_level_nx = ~r_level;
                    end else begin
                        w_cnt_nx = r_cnt + ONE;
                    end
                    w_data_nx = w_level_nx ? amplitude : '0;
                    w_ps_nx   = w_level_nx & ~r_level;
                end
                MODE_SAW_DN: begin
                    if (r_data == '0) begin
                        w_data_nx = amplitude;
                        w_ps_nx   = 1'b1;
                    end else if (r_data > amplitude) begin
                        w_data_nx = amplitude;
                    end else begin
                        w_data_nx = r_data - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data         = r_data;
    assign period_start = r_ps;
    assign o_dbg_dir    = r_dir;

endmodule

// File: tb/tb_wave_gen.sv
module tb_wave_gen;
  import wave_gen_pkg::*;

  localparam int DW = 16;
  localparam int PW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [1:0]    mode;
  logic [DW-1:0] amplitude;
  logic [PW-1:0] prescaler;
  logic          sync_in;
  logic [DW-1:0] data;
  logic          period_start;
  dir_t          dbg_dir;

  always #5 clk = ~clk;

  wave_gen #(.DATA_W(DW), .PRESC_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .mode         (mode),
    .amplitude    (amplitude),
    .prescaler    (prescaler),
`ifdef WAVE_GEN_SYNC_EN
    .sync_in      (sync_in),
`endif
    .data         (data),
    .period_start (period_start),
    .o_dbg_dir    (dbg_dir)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] exp_q[$];   // {period_start, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input int a, input int p);
    ena       = e;
    mode      = m;
    amplitude = DW'(a);
    prescaler = PW'(p);
  endtask

  // ---------------- reference model ----------------
  // Sample-level model of the generator written straight from the waveform rules.
  int m_data, m_up, m_cnt, m_level, m_pc;
  logic [1:0] m_mode;

  function automatic void model_edge();
    int a;
    int ps;
    logic rs;
    a  = int'(amplitude);
    ps = 0;
    rs = (mode != m_mode);
`ifdef WAVE_GEN_SYNC_EN
    rs = rs | sync_in;
`endif
    if (rst || rs) begin
      m_data = 0; m_up = 1; m_cnt = 0; m_level = 0; m_pc = 0; m_mode = mode;
    end else if (!ena) begin
      m_pc = 0;
    end else if (m_pc < int'(prescaler)) begin
      m_pc = m_pc + 1;
    end else begin
      m_pc = 0;
      case (m_mode)
        MODE_TRI: begin
          if (a == 0) m_data = 0;
          else if (m_data > a) begin m_data = a; m_up = 0; end
          else if (m_up == 1) begin
            if (m_data == a) begin m_data = a - 1; m_up = 0; end
            else m_data = m_data + 1;
          end
          else if (m_data == 0) begin m_data = 1; m_up = 1; ps = 1; end
          else m_data = m_data - 1;
        end
        MODE_SAW_UP: begin
          if (m_data >= a) begin m_data = 0; ps = 1; end
          else m_data = m_data + 1;
        end
        MODE_SQUARE: begin
          if (m_cnt >= a) begin
            m_cnt = 0;
            if (m_level == 0) ps = 1;
            m_level = 1 - m_level;
          end else m_cnt = m_cnt + 1;
          m_data = (m_level == 1) ? a : 0;
        end
        default: begin
          if (m_data == 0) begin m_data = a; ps = 1; end
          else if (m_data > a) m_data = a;
          else m_data = m_data - 1;
        end
      endcase
    end
    exp_q.push_back({ps[0], DW'(m_data)});
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       ena;
    logic [1:0] mode;
    int         amp;
    int         presc;
    int         exp_data;
    logic       exp_ps;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic e, input logic [1:0] m, input int a, input int p,
                              input int d, input logic s);
    vec_t v;
    v.ena = e; v.mode = m; v.amp = a; v.presc = p; v.exp_data = d; v.exp_ps = s;
    vecs.push_back(v);
  endfunction

  initial begin
    int tri_seq[8];
    int sq_seq[10];
    int saw_seq[16];
    logic [DW:0] e;

    tri_seq = '{1, 2, 3, 2, 1, 0, 1, 2};
    sq_seq  = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2};
    saw_seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 0};
    for (int i = 0; i < 8; i++)  add(1'b1, MODE_TRI, 3, 0, tri_seq[i], (i == 6));
    // first square/saw entry is the restart edge caused by the mode change
    for (int i = 0; i < 10; i++) add(1'b1, MODE_SQUARE, 2, 0, sq_seq[i], (i == 3 || i == 9));
    for (int i = 0; i < 16; i++) add(1'b1, MODE_SAW_UP, 4, 2, saw_seq[i], (i == 15));

    // reset state
    sync_in = 1'b0;
    rst = 1'b1;
    drive(1'b0, MODE_TRI, 3, 0);
    edges(2);
    check("reset_data", data, 0);
    check("reset_ps", period_start, 0);
    check("reset_dir", dbg_dir, DIR_UP);
    rst = 1'b0;

    // table-driven directed sequences
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ena, vecs[i].mode, vecs[i].amp, vecs[i].presc);
      edge1();
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_ps", i), period_start, vecs[i].exp_ps);
    end

    // triangle clamp when amplitude drops below a rising sample
    drive(1'b1, MODE_TRI, 20, 0);
    edge1();
    check("clamp_restart", data, 0);
    edges(10);
    check("clamp_pre", data, 10);
    amplitude = 6;
    edge1();
    check("clamp_data", data, 6);
    check("clamp_ps", period_start, 0);
    check("clamp_dir", dbg_dir, DIR_DN);
    edge1();
    check("clamp_next", data, 5);
    edge1();
    check("clamp_next2", data, 4);

    // square: ena dropped mid-run freezes the waveform
    drive(1'b1, MODE_SQUARE, 2, 0);
    edge1();
    edges(4);
    check("sq_pre_freeze", data, 2);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      check("sq_frozen_data", data, 2);
      check("sq_frozen_ps", period_start, 0);
    end
    ena = 1'b1;
    edge1();
    check("sq_resume1", data, 2);
    edge1();
    check("sq_resume2", data, 0);

    // mode change coincident with a tick
    drive(1'b1, MODE_TRI, 5, 0);
    edge1();
    edges(3);
    check("mc_pre", data, 3);
    mode = MODE_SAW_DN;
    edge1();
    check("mc_data", data, 0);
    check("mc_ps", period_start, 0);
    edge1();
    check("mc_next_data", data, 5);
    check("mc_next_ps", period_start, 1);
    edge1();
    check("mc_next2", data, 4);

    // reset mid-ramp with ena high
    drive(1'b1, MODE_SAW_UP, 9, 0);
    edge1();
    edges(4);
    check("rst_pre", data, 4);
    rst = 1'b1;
    edge1();
    check("rst_mid_data", data, 0);
    check("rst_mid_ps", period_start, 0);
    rst = 1'b0;
    edge1();
    check("rst_after", data, 1);
`ifdef WAVE_GEN_SYNC_EN
    edges(3);
    check("sync_pre", data, 4);
    sync_in = 1'b1;
    edge1();
    check("sync_data", data, 0);
    check("sync_ps", period_start, 0);
    sync_in = 1'b0;
    edge1();
    check("sync_after", data, 1);
`endif

    // randomized run against the reference model
    exp_q.delete();
    drive(1'b1, MODE_TRI, 5, 0);
    rst = 1'b1;
    model_edge();
    edge1();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        ena = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 79) == 0) amplitude = DW'($urandom_range(0, 12));
        if ($urandom_range(0, 99) == 0) prescaler = PW'($urandom_range(0, 3));
        rst = ($urandom_range(0, 499) == 0);
`ifdef WAVE_GEN_SYNC_EN
        sync_in = ($urandom_range(0, 199) == 0);
`endif
        model_edge();
        edge1();
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_queue: got empty queue expected one entry");
      end else begin
        e = exp_q.pop_front();
        check("rand_data", data, e[DW-1:0]);
        check("rand_ps", period_start, e[DW]);
      end
    end
    rst = 1'b0;
    sync_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
